// File: rtl/hazard_mdu_ctrl.sv
// hazard_mdu_ctrl
//   Execute-stage hazard unit for a five-stage RISC-V pipeline.
//   - Forwarding selects for the EX source muxes (M result has priority over W).
//   - Load-use stall detection between D and E.
//   - Two-state FSM that holds a multi-cycle mul/div op in EX for LATENCY
//     cycles, stalling the front of the pipe and bubbling M meanwhile.
//   - Stall/flush controls for the F, D, E and M pipeline registers.
//   LATENCY is the total number of cycles the op occupies EX; legal range 2..15
//   so that LATENCY-1 fits the 4-bit cycle counter.

module hazard_mdu_ctrl #(
   parameter int LATENCY = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] Rs1D,
   input  logic [4:0] Rs2D,
   input  logic [4:0] Rs1E,
   input  logic [4:0] Rs2E,
   input  logic [4:0] RdE,
   input  logic [4:0] RdM,
   input  logic [4:0] RdW,
   input  logic       RegWriteM,
   input  logic       RegWriteW,
   input  logic       ResultSrcE0,
   input  logic       PCSrcE,
   input  logic       MulDivE,
   output logic [1:0] forwardAE,
   output logic [1:0] forwardBE,
   output logic       stallF,
   output logic       stallD,
   output logic       flushD,
   output logic       stallE,
   output logic       flushE,
   output logic       flushM,
   output logic       mdu_start,
   output logic       mdu_done,
   output logic       mdu_busy
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // Counter value seen on the final cycle of a held op.
   localparam logic [3:0] LAST_CYC = 4'(LATENCY - 1);

   // Forwarding select encodings.
   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   state_t     state_r;
   logic [3:0] cyc_r;
   logic       busy_r;

   logic       lw_stall_s;
   logic       hold_s;
   logic       start_s;
   logic       done_s;

   // Select the bypass source for one EX operand; x0 is never forwarded and
   // the younger M-stage result wins over the W-stage result.
   function automatic logic [1:0] fwd_sel(
      input logic [4:0] rs,
      input logic [4:0] rd_m,
      input logic [4:0] rd_w,
      input logic       we_m,
      input logic       we_w
   );
      logic [1:0] sel;
      if ((rs != 5'd0) && we_m && (rs == rd_m)) begin
         sel = FWD_M;
      end else if ((rs != 5'd0) && we_w && (rs == rd_w)) begin
         sel = FWD_W;
      end else begin
         sel = FWD_RF;
      end
      return sel;
   endfunction

   // Load in E whose destination is read by the instruction in D.
   function automatic logic load_use(
      input logic       is_load,
      input logic [4:0] rd_e,
      input logic [4:0] rs1_d,
      input logic [4:0] rs2_d
   );
      logic hit;
      if (is_load && (rd_e != 5'd0)) begin
         hit = (rs1_d == rd_e) || (rs2_d == rd_e);
      end else begin
         hit = 1'b0;
      end
      return hit;
   endfunction

   // Forwarding selects: pure function of the register numbers, unaffected by reset.
   always_comb begin
      forwardAE = fwd_sel(Rs1E, RdM, RdW, RegWriteM, RegWriteW);
      forwardBE = fwd_sel(Rs2E, RdM, RdW, RegWriteM, RegWriteW);
   end

   // Load-use hazard detection.
   always_comb begin
      lw_stall_s = load_use(ResultSrcE0, RdE, Rs1D, Rs2D);
   end

   // Mul/div sequencing decode: start and hold in the issue cycle, hold while
   // counting, release with a done pulse on the last cycle.
   always_comb begin
      start_s = 1'b0;
      hold_s  = 1'b0;
      done_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (MulDivE) begin
               start_s = 1'b1;
               hold_s  = 1'b1;
            end else begin
               start_s = 1'b0;
               hold_s  = 1'b0;
            end
         end
         BUSY: begin
            if (cyc_r != LAST_CYC) begin
               hold_s = 1'b1;
            end else begin
               done_s = 1'b1;
            end
         end
         default: begin
            start_s = 1'b0;
            hold_s  = 1'b0;
            done_s  = 1'b0;
         end
      endcase
   end

   // Mul/div FSM: state, cycle counter and the registered busy flag.
   // The done cycle always returns to IDLE, so a following op starts one
   // cycle later instead of retriggering on the done cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
         cyc_r   <= 4'd0;
         busy_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (MulDivE) begin
                  state_r <= BUSY;
                  cyc_r   <= 4'd1;
                  busy_r  <= 1'b1;
               end else begin
                  state_r <= IDLE;
                  cyc_r   <= cyc_r;
                  busy_r  <= 1'b0;
               end
            end
            BUSY: begin
               if (cyc_r != LAST_CYC) begin
                  state_r <= BUSY;
                  cyc_r   <= cyc_r + 4'd1;
                  busy_r  <= 1'b1;
               end else begin
                  state_r <= IDLE;
                  cyc_r   <= 4'd0;
                  busy_r  <= 1'b0;
               end
            end
            default: begin
               state_r <= IDLE;
               cyc_r   <= 4'd0;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   // Pipeline controls. Every control is forced low while reset is high so the
   // pipe is released the instant reset asserts, even mid-op. While an op is
   // held, E carries the mul/div, so a branch or load flush there is suppressed.
   always_comb begin
      if (reset) begin
         stallF    = 1'b0;
         stallD    = 1'b0;
         flushD    = 1'b0;
         stallE    = 1'b0;
         flushE    = 1'b0;
         flushM    = 1'b0;
         mdu_start = 1'b0;
         mdu_done  = 1'b0;
         mdu_busy  = 1'b0;
      end else begin
         stallF    = lw_stall_s | hold_s;
         stallD    = lw_stall_s | hold_s;
         flushD    = PCSrcE & ~hold_s;
         stallE    = hold_s;
         flushE    = (lw_stall_s | PCSrcE) & ~hold_s;
         flushM    = hold_s;
         mdu_start = start_s;
         mdu_done  = done_s;
         mdu_busy  = busy_r;
      end
   end

endmodule

// File: tb/tb_hazard_mdu_ctrl.sv
// tb_hazard_mdu_ctrl
//   Table-driven bench for hazard_mdu_ctrl with LATENCY=4. Each record holds
//   the inputs for one cycle and the outputs expected in that cycle; the
//   expectation is queued when the inputs are driven and popped when the
//   outputs are sampled on the falling edge.
//   Control vector bit order:
//   {stallF, stallD, flushD, stallE, flushE, flushM, mdu_start, mdu_done, mdu_busy}

module tb_hazard_mdu_ctrl;

   logic       clk;
   logic       reset;
   logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic       RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MulDivE;
   logic [1:0] forwardAE, forwardBE;
   logic       stallF, stallD, flushD, stallE, flushE, flushM;
   logic       mdu_start, mdu_done, mdu_busy;

   typedef struct {
      string      name;
      logic       rst;
      logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
      logic       rwm, rww, ld, pc, md;
      logic [1:0] fa, fb;
      logic [8:0] ctl;
   } vec_t;

   vec_t tbl[$];
   vec_t seq[$];
   vec_t exp_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   hazard_mdu_ctrl #(.LATENCY(4)) dut (
      .clk(clk), .reset(reset),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RdM(RdM), .RdW(RdW),
      .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .MulDivE(MulDivE),
      .forwardAE(forwardAE), .forwardBE(forwardBE),
      .stallF(stallF), .stallD(stallD), .flushD(flushD),
      .stallE(stallE), .flushE(flushE), .flushM(flushM),
      .mdu_start(mdu_start), .mdu_done(mdu_done), .mdu_busy(mdu_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic vec_t mk(
      input string nm, input logic rst,
      input logic [4:0] rs1d, input logic [4:0] rs2d,
      input logic [4:0] rs1e, input logic [4:0] rs2e,
      input logic [4:0] rde,  input logic [4:0] rdm, input logic [4:0] rdw,
      input logic rwm, input logic rww, input logic ld, input logic pc, input logic md,
      input logic [1:0] fa, input logic [1:0] fb, input logic [8:0] ctl
   );
      vec_t v;
      v.name = nm; v.rst = rst;
      v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e;
      v.rde = rde; v.rdm = rdm; v.rdw = rdw;
      v.rwm = rwm; v.rww = rww; v.ld = ld; v.pc = pc; v.md = md;
      v.fa = fa; v.fb = fb; v.ctl = ctl;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      reset = v.rst;
      Rs1D = v.rs1d; Rs2D = v.rs2d; Rs1E = v.rs1e; Rs2E = v.rs2e;
      RdE = v.rde; RdM = v.rdm; RdW = v.rdw;
      RegWriteM = v.rwm; RegWriteW = v.rww;
      ResultSrcE0 = v.ld; PCSrcE = v.pc; MulDivE = v.md;
   endtask

   task automatic check_outputs();
      vec_t       e;
      logic [8:0] ctl;
      ctl = {stallF, stallD, flushD, stallE, flushE, flushM, mdu_start, mdu_done, mdu_busy};
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_empty: output sampled with no expectation queued");
      end else begin
         e = exp_q.pop_front();
         n_checks++;
         if (forwardAE !== e.fa) begin
            n_fail++;
            $display("FAIL %s forwardAE got %b expected %b", e.name, forwardAE, e.fa);
         end
         n_checks++;
         if (forwardBE !== e.fb) begin
            n_fail++;
            $display("FAIL %s forwardBE got %b expected %b", e.name, forwardBE, e.fb);
         end
         n_checks++;
         if (ctl !== e.ctl) begin
            n_fail++;
            $display("FAIL %s ctl got %b expected %b", e.name, ctl, e.ctl);
         end
      end
   endtask

   // One pipeline cycle: drive just after the rising edge, check on the falling edge.
   task automatic apply(input vec_t v);
      @(posedge clk);
      #1;
      drive(v);
      exp_q.push_back(v);
      @(negedge clk);
      check_outputs();
   endtask

   // Four-cycle mul/div op issued from IDLE with MulDivE held high.
   task automatic mdu_op(input string tag);
      apply(mk({tag, "_c1"}, 1'b0, 5'd0,5'd0,5'd0,5'd0,5'd0,5'd0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00,2'b00, 9'b110101100));
      apply(mk({tag, "_c2"}, 1'b0, 5'd0,5'd0,5'd0,5'd0,5'd0,5'd0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00,2'b00, 9'b110101001));
      apply(mk({tag, "_c3"}, 1'b0, 5'd0,5'd0,5'd0,5'd0,5'd0,5'd0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00,2'b00, 9'b110101001));
      apply(mk({tag, "_c4"}, 1'b0, 5'd0,5'd0,5'd0,5'd0,5'd0,5'd0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00,2'b00, 9'b000000011));
   endtask

   initial begin
      vec_t rv;
      drive(mk("init", 1'b1, 5'd0,5'd0,5'd0,5'd0,5'd0,5'd0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00, 9'd0));

      // Combinational vectors, all with the FSM idle.
      //                name          rst   rs1d  rs2d  rs1e  rs2e  rde   rdm   rdw   rwm  rww  ld   pc   md    fa     fb     ctl
      tbl.push_back(mk("reset_state", 1'b1, 5'd0, 5'd9, 5'd5, 5'd0, 5'd9, 5'd5, 5'd0, 1'b1,1'b0,1'b1,1'b1,1'b1, 2'b10, 2'b00, 9'b000000000));
      tbl.push_back(mk("fwdA_m_prio", 1'b0, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 1'b1,1'b1,1'b0,1'b0,1'b0, 2'b10, 2'b00, 9'b000000000));
      tbl.push_back(mk("fwdA_x0",     1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd5, 5'd5, 1'b1,1'b1,1'b0,1'b0,1'b0, 2'b00, 2'b00, 9'b000000000));
      tbl.push_back(mk("fwdB_w",      1'b0, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd3, 5'd7, 1'b1,1'b1,1'b0,1'b0,1'b0, 2'b00, 2'b01, 9'b000000000));
      tbl.push_back(mk("fwdB_w_nowe", 1'b0, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd3, 5'd7, 1'b1,1'b0,1'b0,1'b0,1'b0, 2'b00, 2'b00, 9'b000000000));
      tbl.push_back(mk("fwdAB_m",     1'b0, 5'd0, 5'd0, 5'd4, 5'd4, 5'd0, 5'd4, 5'd4, 1'b1,1'b1,1'b0,1'b0,1'b0, 2'b10, 2'b10, 9'b000000000));
      tbl.push_back(mk("fwdA_w_mnowe",1'b0, 5'd0, 5'd0, 5'd6, 5'd0, 5'd0, 5'd6, 5'd6, 1'b0,1'b1,1'b0,1'b0,1'b0, 2'b01, 2'b00, 9'b000000000));
      tbl.push_back(mk("lwstall_rs2", 1'b0, 5'd0, 5'd9, 5'd0, 5'd0, 5'd9, 5'd0, 5'd0, 1'b0,1'b0,1'b1,1'b0,1'b0, 2'b00, 2'b00, 9'b110010000));
      tbl.push_back(mk("lw_rd0",      1'b0, 5'd0, 5'd9, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b1,1'b0,1'b0, 2'b00, 2'b00, 9'b000000000));
      tbl.push_back(mk("lwstall_rs1", 1'b0, 5'd9, 5'd0, 5'd0, 5'd0, 5'd9, 5'd0, 5'd0, 1'b0,1'b0,1'b1,1'b0,1'b0, 2'b00, 2'b00, 9'b110010000));
      tbl.push_back(mk("noload",      1'b0, 5'd9, 5'd0, 5'd0, 5'd0, 5'd9, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 2'b00, 9'b000000000));
      tbl.push_back(mk("branch",      1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b1,1'b0, 2'b00, 2'b00, 9'b001010000));
      tbl.push_back(mk("branch_lw",   1'b0, 5'd0, 5'd9, 5'd0, 5'd0, 5'd9, 5'd0, 5'd0, 1'b0,1'b0,1'b1,1'b1,1'b0, 2'b00, 2'b00, 9'b111010000));

      foreach (tbl[i]) apply(tbl[i]);

      // Mul/div op with a load-use hazard and a branch in its second cycle,
      // followed by a back-to-back op and an idle cycle.
      seq.push_back(mk("mdu_c1",      1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00, 2'b00, 9'b110101100));
      seq.push_back(mk("mdu_c2_lw",   1'b0, 5'd0, 5'd9, 5'd0, 5'd0, 5'd9, 5'd0, 5'd0, 1'b0,1'b0,1'b1,1'b1,1'b1, 2'b00, 2'b00, 9'b110101001));
      seq.push_back(mk("mdu_c3",      1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00, 2'b00, 9'b110101001));
      seq.push_back(mk("mdu_c4_done", 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00, 2'b00, 9'b000000011));
      foreach (seq[i]) apply(seq[i]);
      mdu_op("b2b");
      apply(mk("after_b2b",   1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b1,1'b0, 2'b00, 2'b00, 9'b001010000));

      // Reset asserted while the op is BUSY (its second cycle).
      apply(mk("rst_c1",      1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00, 2'b00, 9'b110101100));
      apply(mk("rst_c2",      1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00, 2'b00, 9'b110101001));
      #2;
      rv = mk("rst_midop", 1'b1, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 5'd3, 5'd0, 1'b1,1'b0,1'b0,1'b0,1'b1, 2'b10, 2'b00, 9'b000000000);
      drive(rv);
      exp_q.push_back(rv);
      #1;
      check_outputs();
      MulDivE = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      apply(mk("rst_release", 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 2'b00, 9'b000000000));
      apply(mk("rst_nodone",  1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 2'b00, 9'b000000000));
      mdu_op("restart");
      apply(mk("final_idle",  1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 2'b00, 9'b000000000));

      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_leftover: %0d expectations never compared", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
